// File: rtl/noc_input_unit.sv
// Per-port NoC router input stage: flit FIFO, XY route computation from head flits,
// and a wormhole lock that holds a one-hot request until the packet's tail departs.
module noc_input_unit #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int X_W    = 2,
    parameter int Y_W    = 2,
    parameter int CUR_X  = 0,
    parameter int CUR_Y  = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [DATA_W-1:0]          in_flit,
    input  logic [1:0]                 in_type,
    output logic [4:0]                 req,
    input  logic [4:0]                 grant,
    output logic                       out_valid,
    output logic [DATA_W-1:0]          out_flit,
    output logic [1:0]                 out_type,
    output logic                       locked,
    output logic [$clog2(DEPTH):0]     occupancy,
    output logic                       err_pulse
);

    localparam int NUM_PORTS = 5;
    localparam int PTR_W     = $clog2(DEPTH);
    localparam int CNT_W     = PTR_W + 1;
    localparam int ENTRY_W   = DATA_W + 2;

    localparam logic [2:0] PORT_LOCAL = 3'd0;
    localparam logic [2:0] PORT_EAST  = 3'd1;
    localparam logic [2:0] PORT_WEST  = 3'd2;
    localparam logic [2:0] PORT_NORTH = 3'd3;
    localparam logic [2:0] PORT_SOUTH = 3'd4;

    localparam logic [X_W-1:0] CUR_X_V = X_W'(CUR_X);
    localparam logic [Y_W-1:0] CUR_Y_V = Y_W'(CUR_Y);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_e;

    state_e                 state, next_state;
    logic [2:0]             route_q, route_d, route_calc;
    logic [ENTRY_W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic                   empty;
    logic                   push, pop, drop;
    logic [DATA_W-1:0]      front_flit;
    logic [1:0]             front_type;
    logic [X_W-1:0]         dx;
    logic [Y_W-1:0]         dy;
    logic [NUM_PORTS-1:0]   route_onehot;

    assign empty      = (count == '0);
    assign in_ready   = (count != FULL_COUNT);
    assign push       = in_valid & in_ready;
    assign front_flit = mem[rd_ptr][DATA_W-1:0];
    assign front_type = mem[rd_ptr][ENTRY_W-1:DATA_W];
    assign out_flit   = front_flit;
    assign out_type   = front_type;
    assign occupancy  = count;
    assign locked     = (state == ACTIVE);

    // Flit storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_type, in_flit};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // X is resolved before Y, so a packet only turns once on its way.
    always_comb begin
        dx = front_flit[X_W-1:0];
        dy = front_flit[X_W+Y_W-1:X_W];
        route_calc = PORT_LOCAL;
        if (dx > CUR_X_V) begin
            route_calc = PORT_EAST;
        end else if (dx < CUR_X_V) begin
            route_calc = PORT_WEST;
        end else if (dy > CUR_Y_V) begin
            route_calc = PORT_NORTH;
        end else if (dy < CUR_Y_V) begin
            route_calc = PORT_SOUTH;
        end
    end

    always_comb begin
        route_onehot = '0;
        route_onehot[route_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            route_q   <= '0;
            err_pulse <= 1'b0;
        end else begin
            state     <= next_state;
            route_q   <= route_d;
            err_pulse <= drop;
        end
    end

    // Type bit 0 marks a head (HEAD/HEAD_TAIL); bit 1 marks a tail (TAIL/HEAD_TAIL).
    always_comb begin
        next_state = state;
        route_d    = route_q;
        pop        = 1'b0;
        drop       = 1'b0;
        req        = '0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    if (front_type[0]) begin
                        next_state = ACTIVE;
                        route_d    = route_calc;
                    end else begin
                        pop  = 1'b1;
                        drop = 1'b1;
                    end
                end
            end
            ACTIVE: begin
                if (!empty) begin
                    req = route_onehot;
                    if (grant[route_q]) begin
                        out_valid = 1'b1;
                        pop       = 1'b1;
                        if (front_type[1]) begin
                            next_state = IDLE;
                        end
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_noc_input_unit.sv
// Self-checking bench for noc_input_unit at router (1,1): route table, wormhole,
// backpressure, orphan drop, grant filtering and mid-packet reset.
module tb_noc_input_unit;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;

    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [DATA_W-1:0]    in_flit;
    logic [1:0]           in_type;
    logic [4:0]           req;
    logic [4:0]           grant;
    logic                 out_valid;
    logic [DATA_W-1:0]    out_flit;
    logic [1:0]           out_type;
    logic                 locked;
    logic [2:0]           occupancy;
    logic                 err_pulse;

    bit                   tie_grant;
    logic [4:0]           grant_man;
    bit                   cur_dep;
    int                   checks;
    int                   errors;
    int                   departures;
    int                   run_len;
    int                   last_run;
    logic [DATA_W+1:0]    exp_q[$];

    typedef struct {
        logic [DATA_W-1:0] flit;
        logic [4:0]        exp_req;
    } route_vec_t;

    route_vec_t vecs[8];

    noc_input_unit #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .X_W(2), .Y_W(2), .CUR_X(1), .CUR_Y(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_flit(in_flit), .in_type(in_type), .req(req), .grant(grant),
        .out_valid(out_valid), .out_flit(out_flit), .out_type(out_type),
        .locked(locked), .occupancy(occupancy), .err_pulse(err_pulse)
    );

    assign grant = tie_grant ? req : grant_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drives one flit for one clock; caller is aligned just after a rising edge.
    task automatic applyStimulus(input logic [DATA_W-1:0] f, input logic [1:0] t, input bit dep);
        in_valid = 1'b1;
        in_flit  = f;
        in_type  = t;
        cur_dep  = dep;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cur_dep  = 1'b0;
    endtask

    task automatic runRoute(input logic [DATA_W-1:0] f, input logic [4:0] exp, input int idx);
        applyStimulus(f, 2'b11, 1'b1);
        @(negedge clk);
        checkOutput($sformatf("route%0d_latency_req", idx), req, 5'b0);
        @(negedge clk);
        checkOutput($sformatf("route%0d_req", idx), req, exp);
        checkOutput($sformatf("route%0d_out_valid", idx), out_valid, 1'b1);
        @(negedge clk);
        checkOutput($sformatf("route%0d_req_drop", idx), req, 5'b0);
        checkOutput($sformatf("route%0d_unlocked", idx), locked, 1'b0);
        @(posedge clk);
        #1;
    endtask

    task automatic waitUnlocked(input int budget, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((locked !== 1'b0 || occupancy !== 3'd0) && n < budget);
        checkOutput(name, {locked, occupancy}, 4'b0);
    endtask

    // Scoreboard: accepted flits that must depart are queued, departures pop and compare.
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready && cur_dep) begin
                exp_q.push_back({in_type, in_flit});
            end
            if (out_valid) begin
                departures++;
                run_len++;
                if (exp_q.size() == 0) begin
                    checkOutput("sb_underflow", {out_type, out_flit}, 64'hx);
                end else begin
                    checkOutput("sb_flit", {out_type, out_flit}, exp_q.pop_front());
                end
            end else if (run_len > 0) begin
                last_run = run_len;
                run_len  = 0;
            end
        end
    end

    initial begin
        #20000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int err_cnt;
        bit req_seen;
        int d0;

        vecs[0] = '{32'h0000_000B, 5'b00010};
        vecs[1] = '{32'h0000_0004, 5'b00100};
        vecs[2] = '{32'h0000_000D, 5'b01000};
        vecs[3] = '{32'h0000_0001, 5'b10000};
        vecs[4] = '{32'h0000_0005, 5'b00001};
        vecs[5] = '{32'hFFFF_FFF5, 5'b00001};
        vecs[6] = '{32'hA5A5_A500, 5'b00100};
        vecs[7] = '{32'h1234_5602, 5'b00010};

        checks = 0; errors = 0; departures = 0; run_len = 0; last_run = 0;
        rst_n = 1'b0; in_valid = 1'b0; in_flit = '0; in_type = 2'b00;
        tie_grant = 1'b0; grant_man = '0; cur_dep = 1'b0;

        #12;
        checkOutput("reset_req", req, 5'b0);
        checkOutput("reset_out_valid", out_valid, 1'b0);
        checkOutput("reset_locked", locked, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b1);
        checkOutput("reset_occupancy", occupancy, 3'd0);
        checkOutput("reset_err_pulse", err_pulse, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] route table");
        tie_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            runRoute(vecs[i].flit, vecs[i].exp_req, i);
        end

        $display("[TB] wormhole HEAD/BODY/TAIL to LOCAL");
        tie_grant = 1'b0;
        grant_man = 5'b00001;
        last_run  = 0;
        d0 = departures;
        applyStimulus(32'h0000_0005, 2'b01, 1'b1);
        applyStimulus(32'h1111_0000, 2'b00, 1'b1);
        @(negedge clk);
        checkOutput("worm_req_held", req, 5'b00001);
        checkOutput("worm_out_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(32'h2222_0000, 2'b10, 1'b1);
        waitUnlocked(12, "worm_idle");
        @(negedge clk);
        checkOutput("worm_departures", departures - d0, 3);
        checkOutput("worm_consecutive", last_run, 3);
        grant_man = '0;
        @(posedge clk);
        #1;

        $display("[TB] fill and backpressure");
        applyStimulus(32'h0000_0005, 2'b01, 1'b1);
        applyStimulus(32'h3333_0001, 2'b00, 1'b1);
        applyStimulus(32'h3333_0002, 2'b00, 1'b1);
        applyStimulus(32'h3333_0003, 2'b10, 1'b1);
        in_valid = 1'b1; in_flit = 32'h0000_0005; in_type = 2'b11; cur_dep = 1'b1;
        @(negedge clk);
        checkOutput("full_in_ready", in_ready, 1'b0);
        checkOutput("full_occupancy", occupancy, 3'd4);
        checkOutput("full_req", req, 5'b00001);
        @(posedge clk);
        #1;
        grant_man = 5'b00001;
        @(negedge clk);
        checkOutput("full_held_occupancy", occupancy, 3'd4);
        checkOutput("full_one_grant_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        grant_man = '0;
        @(negedge clk);
        checkOutput("after_pop_occupancy", occupancy, 3'd3);
        checkOutput("after_pop_in_ready", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0; cur_dep = 1'b0;
        @(negedge clk);
        checkOutput("refill_occupancy", occupancy, 3'd4);
        tie_grant = 1'b1;
        waitUnlocked(20, "drain_idle");
        @(posedge clk);
        #1;

        $display("[TB] orphan BODY");
        applyStimulus(32'h4444_0005, 2'b00, 1'b0);
        err_cnt = 0;
        req_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (err_pulse === 1'b1) err_cnt++;
            if (req !== 5'b0) req_seen = 1'b1;
        end
        checkOutput("orphan_err_pulses", err_cnt, 1);
        checkOutput("orphan_req_seen", req_seen, 1'b0);
        checkOutput("orphan_occupancy", occupancy, 3'd0);
        @(posedge clk);
        #1;

        $display("[TB] SOUTH with withheld and spurious grant");
        tie_grant = 1'b0;
        grant_man = '0;
        applyStimulus(32'h0000_0001, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("south_wait%0d_req", i), req, 5'b10000);
            checkOutput($sformatf("south_wait%0d_valid", i), out_valid, 1'b0);
            @(posedge clk);
            #1;
        end
        grant_man = 5'b00010;
        @(negedge clk);
        checkOutput("south_spurious_req", req, 5'b10000);
        checkOutput("south_spurious_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        grant_man = 5'b10000;
        @(negedge clk);
        checkOutput("south_grant_valid", out_valid, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bubble_req", req, 5'b0);
        checkOutput("bubble_locked", locked, 1'b1);
        @(posedge clk);
        #1;
        applyStimulus(32'h5555_0000, 2'b10, 1'b1);
        waitUnlocked(10, "south_idle");
        grant_man = '0;
        @(posedge clk);
        #1;

        $display("[TB] reset mid-packet");
        applyStimulus(32'h0000_0005, 2'b01, 1'b1);
        applyStimulus(32'h6666_0000, 2'b00, 1'b0);
        grant_man = 5'b00001;
        @(negedge clk);
        checkOutput("rst_head_departs", out_valid, 1'b1);
        @(posedge clk);
        #1;
        grant_man = '0;
        #2;
        checkOutput("pre_rst_locked", locked, 1'b1);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        checkOutput("rst_req", req, 5'b0);
        checkOutput("rst_locked", locked, 1'b0);
        checkOutput("rst_occupancy", occupancy, 3'd0);
        checkOutput("rst_out_valid", out_valid, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tie_grant = 1'b1;
        @(posedge clk);
        #1;
        runRoute(32'h0000_000B, 5'b00010, 99);

        repeat (3) @(negedge clk);
        checkOutput("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
